// File: rtl/multiplier_32_seq.sv
// Unsigned 32x32 -> 64-bit shift-and-add multiplier, one multiplier bit per clock,
// with a start/busy/done handshake toward the issue logic.
//
//   state | meaning
//   IDLE  | waiting for start; a/b captured on the accepting edge
//   RUN   | 32 add-and-shift steps through adder_32
//   DONE  | one-cycle done pulse; p already holds the new product

module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

module multiplier_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] p_q, p_d;

    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_c;
    logic [63:0] shifted;

    // A clear multiplier bit adds zero, which leaves {0, acc_hi} as required.
    assign add_b = acc_lo_q[0] ? mcand_q : 32'd0;

    adder_32 u_adder (
        .a     (acc_hi_q),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_c)
    );

    assign shifted = {add_c, add_sum, acc_lo_q[31:1]};

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        p_d      = p_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = 32'd0;
                    acc_lo_d = b;
                    count_d  = 6'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_hi_d = shifted[63:32];
                acc_lo_d = shifted[31:0];
                count_d  = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    p_d     = shifted;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            count_q  <= 6'd0;
            p_q      <= 64'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
            p_q      <= p_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign p    = p_q;
endmodule

// File: tb/tb_multiplier_32_seq.sv
// Bench for multiplier_32_seq: a protocol-level timing model plus a product scoreboard,
// with a monitor that checks busy/done every cycle and p at every done pulse.

module tb_multiplier_32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [63:0] p;

    multiplier_32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    logic [63:0] sb[$];
    logic [63:0] hold = 64'd0;
    logic [63:0] exp_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Timing model: 0 = idle, 1..32 = busy cycles after accept, 33 = done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            sb.delete();
        end else if (m_cnt == 0) begin
            if (start) begin
                sb.push_back(ref_mul(a, b));
                m_cnt = 1;
            end
        end else if (m_cnt == 33) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            hold = 64'd0;
        end else begin
            check("busy", 64'(busy), 64'(m_cnt >= 1 && m_cnt <= 32));
            check("done", 64'(done), 64'(m_cnt == 33));
            if (done) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL p_unexpected: done with p=%h but no operation pending", p);
                end else begin
                    exp_p = sb.pop_front();
                    if (p !== exp_p) begin
                        bad++;
                        $display("FAIL p: got %h expected %h (cycle %0d)", p, exp_p, cyc);
                    end
                    hold = exp_p;
                end
            end else begin
                check("p_hold", p, hold);
            end
        end
    end

    task automatic wait_done(input string name, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: got no done within %0d cycles, required a done pulse", name, max);
        end
    endtask

    task automatic op(input string name, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #2 a = x; b = y; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0; a = $urandom; b = $urandom;
        wait_done(name, 40);
    endtask

    initial begin
        int c0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_p", p, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        op("t1_3x5", 32'd3, 32'd5);
        check("t1_p", p, 64'h0000_0000_0000_000F);
        op("t2_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2_p", p, 64'hFFFF_FFFE_0000_0001);
        op("t3_zero", 32'd0, 32'h1234_5678);
        check("t3a_p", p, 64'd0);
        op("t3_msb", 32'h8000_0000, 32'd2);
        check("t3b_p", p, 64'h1_0000_0000);

        // Re-pulse start during RUN and hold it through DONE: must be ignored.
        @(posedge clk);
        #2 a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 a = 32'd9; b = 32'd9; start = 1'b1;
        wait_done("t4_ignore", 40);
        check("t4_p", p, 64'd42);
        @(posedge clk);
        #2 start = 1'b0;
        repeat (5) @(posedge clk);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk);
        #2 a = $urandom; b = $urandom; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_p", p, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        op("t5_12x12", 32'd12, 32'd12);
        check("t5b_p", p, 64'd144);

        // Back-to-back with start held high.
        @(posedge clk);
        #2 a = 32'd2; b = 32'd3; start = 1'b1;
        wait_done("t6_first", 40);
        check("t6_p", p, 64'd6);
        c0 = cyc;
        for (int k = 0; k < 2; k++) begin
            wait_done("t6_next", 40);
            check("t6_period", 64'(cyc - c0), 64'd34);
            check("t6_p", p, 64'd6);
            c0 = cyc;
        end
        @(posedge clk);
        #2 start = 1'b0;

        // Random traffic: random start, operands change every cycle.
        repeat (1500) begin
            @(posedge clk);
            #2 start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
        end
        @(posedge clk);
        #2 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end
endmodule
